// File: rtl/ct_mat_alu_pkg.sv
// Shared types and constants for the pipe8 matrix ALU issue sequencer:
// FSM state encoding, one-hot op codes and alu meta field positions.
package ct_mat_alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_DRAIN = 2'd2
    } alu_state_e;

    // Bit positions of the fields inside the decoded alu meta word
    localparam int MAT_ALU_OP            = 30;
    localparam int MAT_ALU_OP_LSB        = 20;
    localparam int MAT_ALU_ELM_WIDTH     = 1;
    localparam int MAT_ALU_ELM_WIDTH_LSB = 0;

    localparam logic [10:0] MAT_CAL_ADD = 11'b000_0000_0001;
    localparam logic [10:0] MAT_CAL_SUB = 11'b000_0000_0010;
    localparam logic [10:0] MAT_CAL_MUL = 11'b000_0000_0100;
    localparam logic [10:0] MAT_CAL_MAC = 11'b000_0000_1000;
    localparam logic [10:0] MAT_CAL_MIN = 11'b000_0001_0000;
    localparam logic [10:0] MAT_CAL_MAX = 11'b000_0010_0000;
    localparam logic [10:0] MAT_CAL_AND = 11'b000_0100_0000;
    localparam logic [10:0] MAT_CAL_OR  = 11'b000_1000_0000;
    localparam logic [10:0] MAT_CAL_XOR = 11'b001_0000_0000;
    localparam logic [10:0] MAT_CAL_SLL = 11'b010_0000_0000;
    localparam logic [10:0] MAT_CAL_SRL = 11'b100_0000_0000;

endpackage

// File: rtl/ct_mat_alu_row_sequencer.sv
// Row counter for the matrix ALU: produces the first row index of each beat,
// per-lane valids and the last-beat flag against the latched row count.
module ct_mat_alu_row_sequencer #(
    parameter int ROWS_PER_CYC = 1,
    parameter int SIZEM_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    step,
    input  logic [SIZEM_W-1:0]      sizem,
    output logic [SIZEM_W-1:0]      row_idx,
    output logic [ROWS_PER_CYC-1:0] lane_vld,
    output logic                    last_beat
);

    localparam logic [SIZEM_W:0]   STEP     = (SIZEM_W+1)'(ROWS_PER_CYC);
    localparam logic [SIZEM_W+1:0] STEP_EXT = (SIZEM_W+2)'(ROWS_PER_CYC);

    // One extra bit so the counter can step past 2^SIZEM_W-1 without wrapping
    logic [SIZEM_W:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (start) begin
            cnt_reg <= '0;
        end else if (step) begin
            cnt_reg <= cnt_reg + STEP;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ROWS_PER_CYC; gi++) begin : g_lane
            assign lane_vld[gi] = (cnt_reg + (SIZEM_W+1)'(gi)) < {1'b0, sizem};
        end
    endgenerate

    assign row_idx   = cnt_reg[SIZEM_W-1:0];
    assign last_beat = ({1'b0, cnt_reg} + STEP_EXT) >= {2'b00, sizem};

endmodule

// File: rtl/ct_mat_exu_alu_seq.sv
// Pipe8 matrix ALU issue stage: latches one instruction, sequences its rows,
// drains the result pipe and pulses commit. MAT_ALU_PERF_CNT_EN adds perf counters.
module ct_mat_exu_alu_seq
    import ct_mat_alu_pkg::*;
#(
    parameter int PIPE_DEPTH   = 2,
    parameter int ROWS_PER_CYC = 1,
    parameter int IID_W        = 7,
    parameter int META_W       = 31,
    parameter int SIZEM_W      = 8
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst_b,
    input  logic                    rtu_yy_xx_flush,
    input  logic                    idu_mat_rf_alu_sel,
    input  logic [IID_W-1:0]        idu_mat_rf_pipe8_iid,
    input  logic [META_W-1:0]       idu_mat_rf_pipe8_alu_meta,
    input  logic                    idu_mat_rf_pipe8_alu_src0_vld,
    input  logic [63:0]             idu_mat_rf_pipe8_alu_src0,
    input  logic [SIZEM_W-1:0]      x_sizeM,
    output logic                    mat_alu_idu_rdy,
    output logic                    mat_alu_row_vld,
    output logic [SIZEM_W-1:0]      mat_alu_row_idx,
    output logic [ROWS_PER_CYC-1:0] mat_alu_row_lane_vld,
    output logic [META_W-1:0]       mat_alu_row_meta,
    output logic [63:0]             mat_alu_row_src0,
    output logic                    mat_alu_cbus_ex1_pipe8_sel,
    output logic [IID_W-1:0]        mat_alu_cbus_ex1_pipe8_iid
`ifdef MAT_ALU_PERF_CNT_EN
    ,
    output logic [31:0]             mat_alu_perf_busy_cnt,
    output logic [31:0]             mat_alu_perf_inst_cnt
`endif
);

    localparam int DRAIN_W = 3;

    alu_state_e          state_reg;
    logic [IID_W-1:0]    iid_reg;
    logic [META_W-1:0]   meta_reg;
    logic [63:0]         src0_reg;
    logic [SIZEM_W-1:0]  sizem_reg;
    logic [DRAIN_W-1:0]  drain_reg;
    logic                commit_sel_reg;
    logic [IID_W-1:0]    commit_iid_reg;

    logic                    accept;
    logic                    exec;
    logic [SIZEM_W-1:0]      seq_idx;
    logic [ROWS_PER_CYC-1:0] seq_lane;
    logic                    seq_last;

    assign accept = idu_mat_rf_alu_sel && (state_reg == ST_IDLE) && !rtu_yy_xx_flush;
    assign exec   = (state_reg == ST_EXEC);

    ct_mat_alu_row_sequencer #(
        .ROWS_PER_CYC (ROWS_PER_CYC),
        .SIZEM_W      (SIZEM_W)
    ) u_row_seq (
        .clk       (forever_cpuclk),
        .rst_n     (cpurst_b),
        .start     (accept),
        .step      (exec),
        .sizem     (sizem_reg),
        .row_idx   (seq_idx),
        .lane_vld  (seq_lane),
        .last_beat (seq_last)
    );

    // The commit register is armed on the edge the drain count reaches zero,
    // so the pulse sits in the final DRAIN cycle and drops as we return to IDLE.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state_reg      <= ST_IDLE;
            iid_reg        <= '0;
            meta_reg       <= '0;
            src0_reg       <= '0;
            sizem_reg      <= '0;
            drain_reg      <= '0;
            commit_sel_reg <= 1'b0;
            commit_iid_reg <= '0;
        end else begin
            commit_sel_reg <= 1'b0;
            commit_iid_reg <= '0;
            if (rtu_yy_xx_flush) begin
                state_reg <= ST_IDLE;
                drain_reg <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (idu_mat_rf_alu_sel) begin
                            iid_reg   <= idu_mat_rf_pipe8_iid;
                            meta_reg  <= idu_mat_rf_pipe8_alu_meta;
                            src0_reg  <= idu_mat_rf_pipe8_alu_src0_vld ? idu_mat_rf_pipe8_alu_src0 : 64'd0;
                            sizem_reg <= x_sizeM;
                            state_reg <= ST_EXEC;
                        end
                    end
                    ST_EXEC: begin
                        if (seq_last) begin
                            state_reg <= ST_DRAIN;
                            drain_reg <= DRAIN_W'(PIPE_DEPTH - 1);
                            if (PIPE_DEPTH == 1) begin
                                commit_sel_reg <= 1'b1;
                                commit_iid_reg <= iid_reg;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (drain_reg == '0) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            drain_reg <= drain_reg - 1'b1;
                            if (drain_reg == DRAIN_W'(1)) begin
                                commit_sel_reg <= 1'b1;
                                commit_iid_reg <= iid_reg;
                            end
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    // Lane 0 is valid on every real beat, so it doubles as the beat valid
    assign mat_alu_idu_rdy            = (state_reg == ST_IDLE);
    assign mat_alu_row_vld            = exec && seq_lane[0];
    assign mat_alu_row_idx            = exec ? seq_idx : '0;
    assign mat_alu_row_lane_vld       = exec ? seq_lane : '0;
    assign mat_alu_row_meta           = meta_reg;
    assign mat_alu_row_src0           = src0_reg;
    assign mat_alu_cbus_ex1_pipe8_sel = commit_sel_reg;
    assign mat_alu_cbus_ex1_pipe8_iid = commit_iid_reg;

`ifdef MAT_ALU_PERF_CNT_EN
    logic [31:0] busy_cnt_reg;
    logic [31:0] inst_cnt_reg;

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            busy_cnt_reg <= '0;
            inst_cnt_reg <= '0;
        end else begin
            if (state_reg != ST_IDLE) busy_cnt_reg <= busy_cnt_reg + 32'd1;
            if (commit_sel_reg)       inst_cnt_reg <= inst_cnt_reg + 32'd1;
        end
    end

    assign mat_alu_perf_busy_cnt = busy_cnt_reg;
    assign mat_alu_perf_inst_cnt = inst_cnt_reg;
`endif

endmodule

// File: tb/tb_ct_mat_exu_alu_seq.sv
// Directed bench for ct_mat_exu_alu_seq: three instances (R2/D2, R1/D1, R4/D2)
// share the issue bus, each with its own sel. MAT_ALU_PERF_CNT_EN adds counter checks.
module tb_ct_mat_exu_alu_seq;

    logic        clk = 1'b0;
    logic        rst_b, flush, sel_a, sel_b, sel_c, src0_vld;
    logic [6:0]  iid;
    logic [30:0] meta;
    logic [63:0] src0;
    logic [7:0]  sizem;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    logic        rdy_a, vld_a, csel_a;
    logic [7:0]  idx_a;
    logic [1:0]  lane_a;
    logic [30:0] meta_a;
    logic [63:0] src0_a;
    logic [6:0]  ciid_a;

    logic        rdy_b, vld_b, csel_b;
    logic [7:0]  idx_b;
    logic [0:0]  lane_b;
    logic [30:0] meta_b;
    logic [63:0] src0_b;
    logic [6:0]  ciid_b;

    logic        rdy_c, vld_c, csel_c;
    logic [7:0]  idx_c;
    logic [3:0]  lane_c;
    logic [30:0] meta_c;
    logic [63:0] src0_c;
    logic [6:0]  ciid_c;

`ifdef MAT_ALU_PERF_CNT_EN
    logic [31:0] busy_a, inst_a, busy_b, inst_b, busy_c, inst_c;
`endif

    ct_mat_exu_alu_seq #(.PIPE_DEPTH(2), .ROWS_PER_CYC(2)) dut_a (
        .forever_cpuclk(clk), .cpurst_b(rst_b), .rtu_yy_xx_flush(flush),
        .idu_mat_rf_alu_sel(sel_a), .idu_mat_rf_pipe8_iid(iid),
        .idu_mat_rf_pipe8_alu_meta(meta), .idu_mat_rf_pipe8_alu_src0_vld(src0_vld),
        .idu_mat_rf_pipe8_alu_src0(src0), .x_sizeM(sizem),
        .mat_alu_idu_rdy(rdy_a), .mat_alu_row_vld(vld_a), .mat_alu_row_idx(idx_a),
        .mat_alu_row_lane_vld(lane_a), .mat_alu_row_meta(meta_a), .mat_alu_row_src0(src0_a),
        .mat_alu_cbus_ex1_pipe8_sel(csel_a), .mat_alu_cbus_ex1_pipe8_iid(ciid_a)
`ifdef MAT_ALU_PERF_CNT_EN
        , .mat_alu_perf_busy_cnt(busy_a), .mat_alu_perf_inst_cnt(inst_a)
`endif
    );

    ct_mat_exu_alu_seq #(.PIPE_DEPTH(1), .ROWS_PER_CYC(1)) dut_b (
        .forever_cpuclk(clk), .cpurst_b(rst_b), .rtu_yy_xx_flush(flush),
        .idu_mat_rf_alu_sel(sel_b), .idu_mat_rf_pipe8_iid(iid),
        .idu_mat_rf_pipe8_alu_meta(meta), .idu_mat_rf_pipe8_alu_src0_vld(src0_vld),
        .idu_mat_rf_pipe8_alu_src0(src0), .x_sizeM(sizem),
        .mat_alu_idu_rdy(rdy_b), .mat_alu_row_vld(vld_b), .mat_alu_row_idx(idx_b),
        .mat_alu_row_lane_vld(lane_b), .mat_alu_row_meta(meta_b), .mat_alu_row_src0(src0_b),
        .mat_alu_cbus_ex1_pipe8_sel(csel_b), .mat_alu_cbus_ex1_pipe8_iid(ciid_b)
`ifdef MAT_ALU_PERF_CNT_EN
        , .mat_alu_perf_busy_cnt(busy_b), .mat_alu_perf_inst_cnt(inst_b)
`endif
    );

    ct_mat_exu_alu_seq #(.PIPE_DEPTH(2), .ROWS_PER_CYC(4)) dut_c (
        .forever_cpuclk(clk), .cpurst_b(rst_b), .rtu_yy_xx_flush(flush),
        .idu_mat_rf_alu_sel(sel_c), .idu_mat_rf_pipe8_iid(iid),
        .idu_mat_rf_pipe8_alu_meta(meta), .idu_mat_rf_pipe8_alu_src0_vld(src0_vld),
        .idu_mat_rf_pipe8_alu_src0(src0), .x_sizeM(sizem),
        .mat_alu_idu_rdy(rdy_c), .mat_alu_row_vld(vld_c), .mat_alu_row_idx(idx_c),
        .mat_alu_row_lane_vld(lane_c), .mat_alu_row_meta(meta_c), .mat_alu_row_src0(src0_c),
        .mat_alu_cbus_ex1_pipe8_sel(csel_c), .mat_alu_cbus_ex1_pipe8_iid(ciid_c)
`ifdef MAT_ALU_PERF_CNT_EN
        , .mat_alu_perf_busy_cnt(busy_c), .mat_alu_perf_inst_cnt(inst_c)
`endif
    );

    // Advance past the next rising edge; outputs are then stable for sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_b = 1'b0; flush = 1'b0; sel_a = 1'b0; sel_b = 1'b0; sel_c = 1'b0;
        iid = '0; meta = '0; src0 = '0; src0_vld = 1'b0; sizem = '0;
        repeat (3) tick();
        checks++;
        if ({rdy_a, vld_a, idx_a, lane_a, csel_a, ciid_a} !== {1'b1, 1'b0, 8'd0, 2'd0, 1'b0, 7'd0})
            $display("FAIL reset_ctrl_a: got %h want %h", {rdy_a, vld_a, idx_a, lane_a, csel_a, ciid_a},
                     {1'b1, 1'b0, 8'd0, 2'd0, 1'b0, 7'd0});
        else passed++;
        checks++;
        if ({meta_a, src0_a} !== 95'd0)
            $display("FAIL reset_data_a: got %h want 0", {meta_a, src0_a});
        else passed++;
        checks++;
        if ({rdy_b, vld_b, csel_b, rdy_c, vld_c, csel_c} !== 6'b100100)
            $display("FAIL reset_bc: got %b want 100100", {rdy_b, vld_b, csel_b, rdy_c, vld_c, csel_c});
        else passed++;
        rst_b = 1'b1;
        tick();
    endtask

    // Five rows, two per beat, depth two: beats in cycles 1..3, commit in cycle 5
    task automatic test_basic();
        logic [1:0]  e_lane [1:6];
        logic [20:0] got, exp;
        e_lane = '{2'b11, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00};
        iid = 7'h15; meta = 31'h0040_0002; src0 = 64'hDEAD_BEEF_0123_4567; src0_vld = 1'b1;
        sizem = 8'd5; sel_a = 1'b1;
        tick();
        sel_a = 1'b0; sizem = 8'd9; iid = 7'h00;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            got = {vld_a, idx_a, lane_a, rdy_a, csel_a, ciid_a};
            exp = {(cyc <= 3), (cyc <= 3) ? 8'(2 * (cyc - 1)) : 8'd0, e_lane[cyc],
                   (cyc == 6), (cyc == 5), (cyc == 5) ? 7'h15 : 7'h00};
            checks++;
            if (got !== exp) $display("FAIL basic_cyc%0d: got %h want %h", cyc, got, exp);
            else passed++;
            if (cyc == 1) begin
                checks++;
                if ({meta_a, src0_a} !== {31'h0040_0002, 64'hDEAD_BEEF_0123_4567})
                    $display("FAIL basic_latch: got %h want %h", {meta_a, src0_a},
                             {31'h0040_0002, 64'hDEAD_BEEF_0123_4567});
                else passed++;
            end
            tick();
        end
`ifdef MAT_ALU_PERF_CNT_EN
        checks++;
        if ({busy_a, inst_a} !== {32'd5, 32'd1})
            $display("FAIL perf_cnt: got busy=%0d inst=%0d want busy=5 inst=1", busy_a, inst_a);
        else passed++;
`endif
    endtask

    // Zero rows with depth one: one empty beat, commit in cycle 2
    task automatic test_empty();
        logic [10:0] got, exp;
        iid = 7'h33; sizem = 8'd0; sel_b = 1'b1;
        tick();
        sel_b = 1'b0;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            got = {vld_b, lane_b, rdy_b, csel_b, ciid_b};
            exp = {1'b0, 1'b0, (cyc == 3), (cyc == 2), (cyc == 2) ? 7'h33 : 7'h00};
            checks++;
            if (got !== exp) $display("FAIL empty_cyc%0d: got %h want %h", cyc, got, exp);
            else passed++;
            tick();
        end
    endtask

    task automatic test_flush();
        int ncommit = 0;
        int commit_cyc = -1;
        logic [6:0] commit_iid = '0;
        iid = 7'h0A; src0 = 64'hFFFF_FFFF_FFFF_FFFF; src0_vld = 1'b0; sizem = 8'd5; sel_a = 1'b1;
        tick();
        sel_a = 1'b0;
        checks++;
        if ({vld_a, src0_a} !== {1'b1, 64'd0})
            $display("FAIL flush_src0_zero: got vld=%b src0=%h want vld=1 src0=0", vld_a, src0_a);
        else passed++;
        tick();
        flush = 1'b1; sel_a = 1'b1; iid = 7'h0B; sizem = 8'd2; src0_vld = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if ({vld_a, rdy_a, csel_a} !== 3'b010)
            $display("FAIL flush_cyc3: got vld/rdy/csel=%b want 010", {vld_a, rdy_a, csel_a});
        else passed++;
        tick();
        sel_a = 1'b0;
        checks++;
        if ({vld_a, idx_a, lane_a} !== {1'b1, 8'd0, 2'b11})
            $display("FAIL flush_reaccept: got %h want %h", {vld_a, idx_a, lane_a}, {1'b1, 8'd0, 2'b11});
        else passed++;
        for (int cyc = 4; cyc <= 9; cyc++) begin
            if (csel_a) begin
                ncommit++; commit_cyc = cyc; commit_iid = ciid_a;
            end
            tick();
        end
        checks++;
        if (ncommit != 1 || commit_cyc != 6 || commit_iid !== 7'h0B)
            $display("FAIL flush_commit: got n=%0d cyc=%0d iid=%h want n=1 cyc=6 iid=0b",
                     ncommit, commit_cyc, commit_iid);
        else passed++;
        sel_a = 1'b1; flush = 1'b1;
        tick();
        sel_a = 1'b0; flush = 1'b0;
        checks++;
        if ({rdy_a, vld_a} !== 2'b10)
            $display("FAIL flush_blocks_sel: got rdy/vld=%b want 10", {rdy_a, vld_a});
        else passed++;
        tick();
    endtask

    // sel held through a busy period with a new iid is taken when rdy returns
    task automatic test_back_to_back();
        int ncommit = 0;
        int cyc_q [2] = '{-1, -1};
        logic [6:0] iid_q [2] = '{7'h0, 7'h0};
        iid = 7'h15; sizem = 8'd5; src0_vld = 1'b1; sel_a = 1'b1;
        tick();
        iid = 7'h22;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            if (csel_a) begin
                if (ncommit < 2) begin
                    cyc_q[ncommit] = cyc; iid_q[ncommit] = ciid_a;
                end
                ncommit++;
            end
            if (cyc == 6 || cyc == 7) begin
                checks++;
                if (rdy_a !== (cyc == 6))
                    $display("FAIL b2b_rdy_cyc%0d: got %b want %b", cyc, rdy_a, (cyc == 6));
                else passed++;
            end
            if (cyc == 7) sel_a = 1'b0;
            tick();
        end
        checks++;
        if (ncommit != 2) $display("FAIL b2b_count: got %0d want 2", ncommit);
        else passed++;
        checks++;
        if (cyc_q[0] != 5 || iid_q[0] !== 7'h15)
            $display("FAIL b2b_first: got cyc=%0d iid=%h want cyc=5 iid=15", cyc_q[0], iid_q[0]);
        else passed++;
        checks++;
        if (cyc_q[1] != 11 || iid_q[1] !== 7'h22)
            $display("FAIL b2b_second: got cyc=%0d iid=%h want cyc=11 iid=22", cyc_q[1], iid_q[1]);
        else passed++;
    endtask

    // 255 rows, four per beat: 64 beats, last beat partial, commit in cycle 66
    task automatic test_wide();
        int beats = 0;
        int bad_idx = 0;
        int commit_cyc = -1;
        logic [7:0] last_idx = '0;
        logic [3:0] last_lane = '0;
        iid = 7'h44; sizem = 8'd255; sel_c = 1'b1;
        tick();
        sel_c = 1'b0;
        for (int cyc = 1; cyc <= 70; cyc++) begin
            if (vld_c) begin
                if (idx_c !== 8'(4 * beats)) bad_idx++;
                last_idx = idx_c; last_lane = lane_c; beats++;
            end
            if (csel_c) commit_cyc = cyc;
            tick();
        end
        checks++;
        if (beats != 64) $display("FAIL wide_beats: got %0d want 64", beats);
        else passed++;
        checks++;
        if ({last_idx, last_lane} !== {8'd252, 4'b0111})
            $display("FAIL wide_last: got idx=%0d lane=%b want idx=252 lane=0111", last_idx, last_lane);
        else passed++;
        checks++;
        if (bad_idx != 0) $display("FAIL wide_idx_seq: got %0d bad beats want 0", bad_idx);
        else passed++;
        checks++;
        if (commit_cyc != 66) $display("FAIL wide_commit: got cycle %0d want 66", commit_cyc);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int ncommit = 0;
        iid = 7'h55; sizem = 8'd5; src0 = 64'h1234; src0_vld = 1'b1; sel_a = 1'b1;
        tick();
        sel_a = 1'b0;
        tick();
        rst_b = 1'b0;
        tick();
        checks++;
        if ({rdy_a, vld_a, csel_a, meta_a, src0_a} !== {1'b1, 1'b0, 1'b0, 31'd0, 64'd0})
            $display("FAIL reset_mid_state: got rdy=%b vld=%b csel=%b meta=%h src0=%h want 1 0 0 0 0",
                     rdy_a, vld_a, csel_a, meta_a, src0_a);
        else passed++;
        rst_b = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (csel_a) ncommit++;
            tick();
        end
        checks++;
        if (ncommit != 0) $display("FAIL reset_mid_commit: got %0d commits want 0", ncommit);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_flush();
        test_back_to_back();
        test_wide();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
